// File: rtl/regfile_write_arbiter_if.sv
// Bundles the writeback, multi-cycle, decode-check and regfile-port signals of the write arbiter.
interface regfile_write_arbiter_if #(
  parameter int SIZE       = 32,
  parameter int AMOUNT_REG = 4
);
  logic                     P_WE;
  logic [AMOUNT_REG-1:0]    P_WA;
  logic [SIZE-1:0]          P_WD;
  logic                     C_VALID;
  logic                     C_READY;
  logic [AMOUNT_REG-1:0]    C_WA;
  logic [SIZE-1:0]          C_WD;
  logic                     C_ISSUE;
  logic [AMOUNT_REG-1:0]    C_ISSUE_RA;
  logic [AMOUNT_REG-1:0]    CHK_RA1;
  logic [AMOUNT_REG-1:0]    CHK_RA2;
  logic                     STALL;
  logic [2**AMOUNT_REG-1:0] PENDING;
  logic                     WE3;
  logic [AMOUNT_REG-1:0]    RA3;
  logic [SIZE-1:0]          WD3;

  modport master (
    output P_WE, P_WA, P_WD, C_VALID, C_WA, C_WD, C_ISSUE, C_ISSUE_RA, CHK_RA1, CHK_RA2,
    input  C_READY, STALL, PENDING, WE3, RA3, WD3
  );

  modport slave (
    input  P_WE, P_WA, P_WD, C_VALID, C_WA, C_WD, C_ISSUE, C_ISSUE_RA, CHK_RA1, CHK_RA2,
    output C_READY, STALL, PENDING, WE3, RA3, WD3
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares the regfile write port between writeback (priority) and a multi-cycle unit,
// with a pending-result scoreboard and a starvation guard that stalls decode.
module regfile_write_arbiter #(
  parameter int SIZE         = 32,
  parameter int AMOUNT_REG   = 4,
  parameter int STARVE_LIMIT = 4
) (
  input logic                     CLK,
  input logic                     RESET,
  regfile_write_arbiter_if.slave  bus
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);
  localparam logic [AMOUNT_REG-1:0] PC_REG = AMOUNT_REG'(15);

  typedef enum logic {NORMAL, STARVE} state_t;

  state_t                   state, state_next;
  logic [CW-1:0]            count, count_next, count_inc;
  logic [2**AMOUNT_REG-1:0] pending, pending_next;
  logic                     c_accept;
  logic                     inflight_hit;

  assign c_accept    = !RESET && bus.C_VALID && !bus.P_WE;
  assign bus.C_READY = c_accept;
  assign bus.PENDING = pending;

  // Regfile latches data only at the next edge, so a read in the same cycle sees stale data.
  assign inflight_hit = bus.WE3 && (bus.RA3 != PC_REG) &&
                        ((bus.RA3 == bus.CHK_RA1) || (bus.RA3 == bus.CHK_RA2));

  assign bus.STALL = !RESET && ((state == STARVE) || pending[bus.CHK_RA1] ||
                                pending[bus.CHK_RA2] || inflight_hit);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      bus.WE3 <= 1'b0;
      bus.RA3 <= '0;
      bus.WD3 <= '0;
    end else if (bus.P_WE) begin
      bus.WE3 <= 1'b1;
      bus.RA3 <= bus.P_WA;
      bus.WD3 <= bus.P_WD;
    end else if (c_accept) begin
      bus.WE3 <= 1'b1;
      bus.RA3 <= bus.C_WA;
      bus.WD3 <= bus.C_WD;
    end else begin
      bus.WE3 <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= NORMAL;
      count   <= '0;
      pending <= '0;
    end else begin
      state   <= state_next;
      count   <= count_next;
      pending <= pending_next;
    end
  end

  always_comb begin
    state_next = state;
    count_next = count;
    count_inc  = (count == LIMIT) ? count : count + 1'b1;
    case (state)
      NORMAL: begin
        if (bus.C_VALID && bus.P_WE) begin
          count_next = count_inc;
          if (count_inc == LIMIT) state_next = STARVE;
        end else begin
          count_next = '0;
        end
      end
      STARVE: begin
        if (c_accept) begin
          state_next = NORMAL;
          count_next = '0;
        end
      end
      default: begin
        state_next = NORMAL;
        count_next = '0;
      end
    endcase
  end

  // Set is applied after clear so a same-cycle issue to the same register wins.
  always_comb begin
    pending_next = pending;
    if (c_accept) pending_next[bus.C_WA] = 1'b0;
    if (bus.C_ISSUE && (bus.C_ISSUE_RA != PC_REG)) pending_next[bus.C_ISSUE_RA] = 1'b1;
  end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: write port, grant, starvation, scoreboard, reset.
module tb_regfile_write_arbiter;
  logic CLK = 1'b0;
  logic RESET;
  int checks = 0;
  int failures = 0;

  regfile_write_arbiter_if #(.SIZE(32), .AMOUNT_REG(4)) bus ();

  regfile_write_arbiter #(.SIZE(32), .AMOUNT_REG(4), .STARVE_LIMIT(4)) dut (
    .CLK(CLK), .RESET(RESET), .bus(bus.slave)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    bus.P_WE = 1'b0; bus.P_WA = '0; bus.P_WD = '0;
    bus.C_VALID = 1'b0; bus.C_WA = '0; bus.C_WD = '0;
    bus.C_ISSUE = 1'b0; bus.C_ISSUE_RA = '0;
    bus.CHK_RA1 = 4'd15; bus.CHK_RA2 = 4'd15;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    idle();
    bus.C_VALID = 1'b1;
    step(); step();
    checks++; if (bus.C_READY !== 1'b0) begin failures++; $display("FAIL rst_c_ready got=%0b exp=0", bus.C_READY); end
    checks++; if (bus.STALL !== 1'b0) begin failures++; $display("FAIL rst_stall got=%0b exp=0", bus.STALL); end
    checks++; if (bus.WE3 !== 1'b0) begin failures++; $display("FAIL rst_we3 got=%0b exp=0", bus.WE3); end
    checks++; if (bus.RA3 !== 4'd0) begin failures++; $display("FAIL rst_ra3 got=%0h exp=0", bus.RA3); end
    checks++; if (bus.WD3 !== 32'd0) begin failures++; $display("FAIL rst_wd3 got=%0h exp=0", bus.WD3); end
    checks++; if (bus.PENDING !== 16'h0000) begin failures++; $display("FAIL rst_pending got=%0h exp=0", bus.PENDING); end
    idle();
    RESET = 1'b0;
    step();
  endtask

  task automatic test_pipe_write();
    bus.P_WE = 1'b1; bus.P_WA = 4'd3; bus.P_WD = 32'h0000_00A5;
    step();
    idle();
    checks++; if (bus.WE3 !== 1'b1) begin failures++; $display("FAIL pw_we3 got=%0b exp=1", bus.WE3); end
    checks++; if (bus.RA3 !== 4'd3) begin failures++; $display("FAIL pw_ra3 got=%0h exp=3", bus.RA3); end
    checks++; if (bus.WD3 !== 32'h0000_00A5) begin failures++; $display("FAIL pw_wd3 got=%0h exp=a5", bus.WD3); end
    step();
    checks++; if (bus.WE3 !== 1'b0) begin failures++; $display("FAIL pw_we3_off got=%0b exp=0", bus.WE3); end
    checks++; if (bus.RA3 !== 4'd3) begin failures++; $display("FAIL pw_ra3_hold got=%0h exp=3", bus.RA3); end
    checks++; if (bus.WD3 !== 32'h0000_00A5) begin failures++; $display("FAIL pw_wd3_hold got=%0h exp=a5", bus.WD3); end
  endtask

  task automatic test_c_write();
    bus.C_VALID = 1'b1; bus.C_WA = 4'd5; bus.C_WD = 32'h1234_5678;
    #1;
    checks++; if (bus.C_READY !== 1'b1) begin failures++; $display("FAIL cw_ready got=%0b exp=1", bus.C_READY); end
    step();
    idle();
    checks++; if (bus.WE3 !== 1'b1) begin failures++; $display("FAIL cw_we3 got=%0b exp=1", bus.WE3); end
    checks++; if (bus.RA3 !== 4'd5) begin failures++; $display("FAIL cw_ra3 got=%0h exp=5", bus.RA3); end
    checks++; if (bus.WD3 !== 32'h1234_5678) begin failures++; $display("FAIL cw_wd3 got=%0h exp=12345678", bus.WD3); end
    step();
  endtask

  task automatic test_starve();
    bus.C_VALID = 1'b1; bus.C_WA = 4'd9; bus.C_WD = 32'hDEAD_BEEF;
    bus.P_WE = 1'b1; bus.P_WA = 4'd1; bus.P_WD = 32'h11;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (bus.C_READY !== 1'b0) begin failures++; $display("FAIL st_ready_c%0d got=%0b exp=0", i, bus.C_READY); end
      checks++; if (bus.STALL !== 1'b0) begin failures++; $display("FAIL st_stall_c%0d got=%0b exp=0", i, bus.STALL); end
      step();
    end
    checks++; if (bus.RA3 !== 4'd1) begin failures++; $display("FAIL st_pipe_prio got=%0h exp=1", bus.RA3); end
    checks++; if (bus.STALL !== 1'b1) begin failures++; $display("FAIL st_stall5 got=%0b exp=1", bus.STALL); end
    bus.P_WE = 1'b0;
    #1;
    checks++; if (bus.C_READY !== 1'b1) begin failures++; $display("FAIL st_accept got=%0b exp=1", bus.C_READY); end
    checks++; if (bus.STALL !== 1'b1) begin failures++; $display("FAIL st_stall_acc got=%0b exp=1", bus.STALL); end
    step();
    idle();
    #1;
    checks++; if (bus.STALL !== 1'b0) begin failures++; $display("FAIL st_release got=%0b exp=0", bus.STALL); end
    checks++; if (bus.RA3 !== 4'd9 || bus.WE3 !== 1'b1) begin failures++; $display("FAIL st_cwrite got=we%0b/ra%0h exp=we1/ra9", bus.WE3, bus.RA3); end
    step();
  endtask

  task automatic test_hazard();
    bus.C_ISSUE = 1'b1; bus.C_ISSUE_RA = 4'd7;
    step();
    idle();
    bus.CHK_RA1 = 4'd7;
    #1;
    checks++; if (bus.PENDING !== 16'h0080) begin failures++; $display("FAIL hz_pending got=%0h exp=80", bus.PENDING); end
    checks++; if (bus.STALL !== 1'b1) begin failures++; $display("FAIL hz_stall_pend got=%0b exp=1", bus.STALL); end
    bus.P_WE = 1'b1; bus.P_WA = 4'd7; bus.P_WD = 32'h77;
    step();
    bus.P_WE = 1'b0;
    #1;
    checks++; if (bus.WE3 !== 1'b1 || bus.RA3 !== 4'd7) begin failures++; $display("FAIL hz_pwe_pending got=we%0b/ra%0h exp=we1/ra7", bus.WE3, bus.RA3); end
    checks++; if (bus.PENDING !== 16'h0080) begin failures++; $display("FAIL hz_pend_kept got=%0h exp=80", bus.PENDING); end
    bus.C_VALID = 1'b1; bus.C_WA = 4'd7; bus.C_WD = 32'h700;
    #1;
    checks++; if (bus.C_READY !== 1'b1) begin failures++; $display("FAIL hz_accept got=%0b exp=1", bus.C_READY); end
    checks++; if (bus.STALL !== 1'b1) begin failures++; $display("FAIL hz_stall_acc got=%0b exp=1", bus.STALL); end
    step();
    bus.C_VALID = 1'b0;
    #1;
    checks++; if (bus.PENDING !== 16'h0000) begin failures++; $display("FAIL hz_cleared got=%0h exp=0", bus.PENDING); end
    checks++; if (bus.STALL !== 1'b1) begin failures++; $display("FAIL hz_stall_inflight got=%0b exp=1", bus.STALL); end
    step();
    checks++; if (bus.STALL !== 1'b0) begin failures++; $display("FAIL hz_stall_done got=%0b exp=0", bus.STALL); end
    idle();
    step();
  endtask

  task automatic test_set_wins();
    bus.C_ISSUE = 1'b1; bus.C_ISSUE_RA = 4'd2;
    bus.C_VALID = 1'b1; bus.C_WA = 4'd2;
    #1;
    checks++; if (bus.C_READY !== 1'b1) begin failures++; $display("FAIL sw_ready got=%0b exp=1", bus.C_READY); end
    step();
    idle();
    checks++; if (bus.PENDING !== 16'h0004) begin failures++; $display("FAIL sw_set_wins got=%0h exp=4", bus.PENDING); end
    bus.C_ISSUE = 1'b1; bus.C_ISSUE_RA = 4'd15;
    step();
    idle();
    checks++; if (bus.PENDING !== 16'h0004) begin failures++; $display("FAIL sw_pc_ignored got=%0h exp=4", bus.PENDING); end
    bus.C_VALID = 1'b1; bus.C_WA = 4'd2;
    step();
    idle();
    checks++; if (bus.PENDING !== 16'h0000) begin failures++; $display("FAIL sw_clear got=%0h exp=0", bus.PENDING); end
    step();
  endtask

  task automatic test_reset_mid();
    bus.C_ISSUE = 1'b1; bus.C_ISSUE_RA = 4'd3;
    step();
    bus.C_ISSUE_RA = 4'd7;
    step();
    idle();
    checks++; if (bus.PENDING !== 16'h0088) begin failures++; $display("FAIL rm_pending got=%0h exp=88", bus.PENDING); end
    bus.C_VALID = 1'b1; bus.C_WA = 4'd1; bus.P_WE = 1'b1; bus.P_WA = 4'd4;
    step(); step(); step(); step();
    checks++; if (bus.STALL !== 1'b1) begin failures++; $display("FAIL rm_starve got=%0b exp=1", bus.STALL); end
    RESET = 1'b1;
    bus.P_WE = 1'b0;
    #1;
    checks++; if (bus.STALL !== 1'b0) begin failures++; $display("FAIL rm_stall_in_rst got=%0b exp=0", bus.STALL); end
    checks++; if (bus.C_READY !== 1'b0) begin failures++; $display("FAIL rm_ready_in_rst got=%0b exp=0", bus.C_READY); end
    step();
    checks++; if (bus.PENDING !== 16'h0000) begin failures++; $display("FAIL rm_pending_clr got=%0h exp=0", bus.PENDING); end
    checks++; if (bus.WE3 !== 1'b0) begin failures++; $display("FAIL rm_we3 got=%0b exp=0", bus.WE3); end
    RESET = 1'b0;
    idle();
    #1;
    checks++; if (bus.STALL !== 1'b0) begin failures++; $display("FAIL rm_stall_after got=%0b exp=0", bus.STALL); end
    step();
    checks++; if (bus.WE3 !== 1'b0) begin failures++; $display("FAIL rm_dropped got=%0b exp=0", bus.WE3); end
  endtask

  initial begin
    test_reset();
    test_pipe_write();
    test_c_write();
    test_starve();
    test_hazard();
    test_set_wins();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
